// File: rtl/psu_sw_seq.sv
`default_nettype none
// ============================================================================
// Module      : psu_sw_seq
// Description : Multi-channel 12V source selector for DIMM / S3 VR rails.
//               Follows the PCH sleep states (S4/S5, S3, S0) and PSU
//               power-good to power every channel either from 12V_STBY or
//               from 12V main. The hand-over into main can be either
//               make-before-break or break-before-make.
//
// Ports       :
//   iClk                    system clock
//   iRst_n                  synchronous active-low reset
//   ienable                 master enable; low freezes the FSM and the timer
//   iPWRGD_PS_PWROK         PSU power good (async)
//   iFM_SLP3_N              PCH SLP_S3# (async)
//   iFM_SLP4_N              PCH SLP_S4# (async)
//   iFM_DIMM_12V_CPS_SX_N   per-channel strap, 0 = keep STBY in S4/S5 (async)
//   oFM_AUX_SW_EN           per-channel 12V main aux switch enable
//   oFM_S3_SW_P12V_STBY_EN  per-channel "feed VR from 12V_STBY"
//   oFM_S3_SW_P12V_EN       per-channel "feed VR from 12V main"
//   oFault                  PWROK timeout fault
//   oState                  current state code (debug / BMC)
//
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module psu_sw_seq #(
    parameter int NUM_CH          = 2,
    parameter int HOLD_CYCLES     = 50000,
    parameter int PWROK_TO_CYCLES = 5000000,
    parameter int DEB_CYCLES      = 500,
    parameter int MBB             = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              ienable,
    input  logic              iPWRGD_PS_PWROK,
    input  logic              iFM_SLP3_N,
    input  logic              iFM_SLP4_N,
    input  logic [NUM_CH-1:0] iFM_DIMM_12V_CPS_SX_N,
    output logic [NUM_CH-1:0] oFM_AUX_SW_EN,
    output logic [NUM_CH-1:0] oFM_S3_SW_P12V_STBY_EN,
    output logic [NUM_CH-1:0] oFM_S3_SW_P12V_EN,
    output logic              oFault,
    output logic [2:0]        oState
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_INIT   = 3'd0;
    localparam logic [2:0] c_ST_S45    = 3'd1;
    localparam logic [2:0] c_ST_S3     = 3'd2;
    localparam logic [2:0] c_ST_S0WAIT = 3'd3;
    localparam logic [2:0] c_ST_S0HOLD = 3'd4;
    localparam logic [2:0] c_ST_S0ON   = 3'd5;
    localparam logic [2:0] c_ST_FAULT  = 3'd6;

    // ------------------------------------------------------------------
    // Derived sizes and compare values
    // ------------------------------------------------------------------
    localparam int c_TMAX  = (HOLD_CYCLES > PWROK_TO_CYCLES) ? HOLD_CYCLES : PWROK_TO_CYCLES;
    localparam int c_CNT_W = $clog2(c_TMAX + 1);
    localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_SYNC_W = NUM_CH + 3;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(PWROK_TO_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST   = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic               c_MBB        = (MBB != 0);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [c_SYNC_W-1:0] r_syncMeta;
    logic [c_SYNC_W-1:0] r_sync;
    logic                w_pwrokSync;
    logic                w_slp3;
    logic                w_slp4;
    logic [NUM_CH-1:0]   w_cpsN;

    logic                r_pwrokDb;
    logic [c_DEB_W-1:0]  r_debCnt;

    logic [2:0]          r_state;
    logic [2:0]          w_nextState;
    logic [c_CNT_W-1:0]  r_timer;
    logic                w_timerRun;

    logic [NUM_CH-1:0]   w_auxEn;
    logic [NUM_CH-1:0]   w_stbyEn;
    logic [NUM_CH-1:0]   w_mainEn;
    logic                w_fault;

    logic [NUM_CH-1:0]   r_auxEn;
    logic [NUM_CH-1:0]   r_stbyEn;
    logic [NUM_CH-1:0]   r_mainEn;
    logic                r_fault;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for every asynchronous input. Packed as one
    // vector: {PWROK, SLP3#, SLP4#, CPS_N[NUM_CH-1:0]}.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_syncMeta <= '0;
            r_sync     <= '0;
        end else begin
            r_syncMeta <= {iPWRGD_PS_PWROK, iFM_SLP3_N, iFM_SLP4_N, iFM_DIMM_12V_CPS_SX_N};
            r_sync     <= r_syncMeta;
        end
    end

    assign w_pwrokSync = r_sync[NUM_CH+2];
    assign w_slp3      = r_sync[NUM_CH+1];
    assign w_slp4      = r_sync[NUM_CH];
    assign w_cpsN      = r_sync[NUM_CH-1:0];

    // ------------------------------------------------------------------
    // PWROK debounce: the debounced value follows the synchronised value
    // only after DEB_CYCLES consecutive cycles of disagreement. Any cycle
    // in which the two agree restarts the count. Runs independently of
    // ienable so the debounced view stays current while frozen.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_pwrokDb <= 1'b0;
            r_debCnt  <= '0;
        end else if (w_pwrokSync == r_pwrokDb) begin
            r_debCnt  <= '0;
        end else if (r_debCnt == c_DEB_LAST) begin
            r_pwrokDb <= w_pwrokSync;
            r_debCnt  <= '0;
        end else begin
            r_debCnt  <= r_debCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state and output registers. Outputs are decoded from
    // the next state so they switch on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state  <= c_ST_INIT;
            r_auxEn  <= '0;
            r_stbyEn <= '0;
            r_mainEn <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_auxEn  <= w_auxEn;
            r_stbyEn <= w_stbyEn;
            r_mainEn <= w_mainEn;
            r_fault  <= w_fault;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic. Within each state the checks are
    // evaluated in priority order; the first match wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        if (r_state > c_ST_FAULT) begin
            // Unused codes recover to INIT even while frozen.
            w_nextState = c_ST_INIT;
        end else if (!ienable) begin
            // Frozen; INIT cannot leave without ienable anyway.
            w_nextState = r_state;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    if (!w_slp3 && !w_slp4 && !r_pwrokDb)
                        w_nextState = c_ST_S45;
                end
                c_ST_S45: begin
                    if (!w_slp3 && w_slp4)
                        w_nextState = c_ST_S3;
                    else if (w_slp3 || r_pwrokDb)
                        w_nextState = c_ST_INIT;
                end
                c_ST_S3: begin
                    if (!w_slp4)
                        w_nextState = c_ST_S45;
                    else if (w_slp3 && !r_pwrokDb)
                        w_nextState = c_ST_S0WAIT;
                    else if (r_pwrokDb && !w_slp3)
                        w_nextState = c_ST_INIT;
                end
                c_ST_S0WAIT: begin
                    if (r_pwrokDb && w_slp3)
                        w_nextState = c_ST_S0HOLD;
                    else if (!w_slp3 && w_slp4)
                        w_nextState = c_ST_S3;
                    else if (!w_slp4)
                        w_nextState = c_ST_INIT;
                    else if (r_timer == c_TO_LAST)
                        w_nextState = c_ST_FAULT;
                end
                c_ST_S0HOLD: begin
                    // Sleep requests cut the hold window short.
                    if (!w_slp3 && w_slp4)
                        w_nextState = c_ST_S3;
                    else if (!w_slp4)
                        w_nextState = c_ST_INIT;
                    else if (r_timer == c_HOLD_LAST)
                        w_nextState = r_pwrokDb ? c_ST_S0ON : c_ST_S0WAIT;
                end
                c_ST_S0ON: begin
                    if (!w_slp3 && w_slp4)
                        w_nextState = c_ST_S3;
                    else if (!w_slp4)
                        w_nextState = c_ST_INIT;
                    else if (!r_pwrokDb)
                        w_nextState = c_ST_S0WAIT;
                end
                c_ST_FAULT: begin
                    if (!w_slp3)
                        w_nextState = c_ST_INIT;
                end
                default: w_nextState = c_ST_INIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: output decode of the next state. AUX and STBY are
    // never asserted together in any state.
    // ------------------------------------------------------------------
    always_comb begin
        w_auxEn  = '0;
        w_stbyEn = '0;
        w_mainEn = '0;
        w_fault  = 1'b0;
        case (w_nextState)
            c_ST_S45: begin
                // Strap is only honoured here; elsewhere it is ignored.
                w_stbyEn = ~w_cpsN;
            end
            c_ST_S3, c_ST_S0WAIT: begin
                w_stbyEn = '1;
            end
            c_ST_S0HOLD: begin
                // Make-before-break overlaps both sources; break-before-make
                // leaves the rail unpowered for the hold window.
                if (c_MBB) begin
                    w_stbyEn = '1;
                    w_mainEn = '1;
                end
            end
            c_ST_S0ON: begin
                w_auxEn  = '1;
                w_mainEn = '1;
            end
            c_ST_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_auxEn  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared timer: cleared on any state change, counts in S0WAIT/S0HOLD,
    // saturates at all-ones, holds while disabled.
    // ------------------------------------------------------------------
    assign w_timerRun = ienable && ((r_state == c_ST_S0WAIT) || (r_state == c_ST_S0HOLD));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_timer <= '0;
        end else if (w_nextState != r_state) begin
            r_timer <= '0;
        end else if (w_timerRun && (r_timer != {c_CNT_W{1'b1}})) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign oFM_AUX_SW_EN          = r_auxEn;
    assign oFM_S3_SW_P12V_STBY_EN = r_stbyEn;
    assign oFM_S3_SW_P12V_EN      = r_mainEn;
    assign oFault                 = r_fault;
    assign oState                 = r_state;

endmodule
`default_nettype wire

// File: tb/tb_psu_sw_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_psu_sw_seq
// Description : Directed self-checking bench for psu_sw_seq. Two instances
//               share all inputs: uMbb (make-before-break) and uBbm
//               (break-before-make). HOLD=8, PWROK timeout=32, debounce=3.
// Revision    : 1.0 - initial
// ============================================================================
module tb_psu_sw_seq;

    localparam logic [2:0] c_INIT   = 3'd0;
    localparam logic [2:0] c_S45    = 3'd1;
    localparam logic [2:0] c_S3     = 3'd2;
    localparam logic [2:0] c_S0WAIT = 3'd3;
    localparam logic [2:0] c_S0HOLD = 3'd4;
    localparam logic [2:0] c_S0ON   = 3'd5;
    localparam logic [2:0] c_FAULT  = 3'd6;

    logic       iClk;
    logic       iRst_n;
    logic       ienable;
    logic       pwrok;
    logic       slp3;
    logic       slp4;
    logic [1:0] cpsN;

    logic [1:0] auxA, stbyA, mainA;
    logic       faultA;
    logic [2:0] stateA;
    logic [1:0] auxB, stbyB, mainB;
    logic       faultB;
    logic [2:0] stateB;

    int nChecks = 0;
    int nPass   = 0;
    int n;

    psu_sw_seq #(
        .NUM_CH(2), .HOLD_CYCLES(8), .PWROK_TO_CYCLES(32), .DEB_CYCLES(3), .MBB(1)
    ) uMbb (
        .iClk                  (iClk),
        .iRst_n                (iRst_n),
        .ienable               (ienable),
        .iPWRGD_PS_PWROK       (pwrok),
        .iFM_SLP3_N            (slp3),
        .iFM_SLP4_N            (slp4),
        .iFM_DIMM_12V_CPS_SX_N (cpsN),
        .oFM_AUX_SW_EN         (auxA),
        .oFM_S3_SW_P12V_STBY_EN(stbyA),
        .oFM_S3_SW_P12V_EN     (mainA),
        .oFault                (faultA),
        .oState                (stateA)
    );

    psu_sw_seq #(
        .NUM_CH(2), .HOLD_CYCLES(8), .PWROK_TO_CYCLES(32), .DEB_CYCLES(3), .MBB(0)
    ) uBbm (
        .iClk                  (iClk),
        .iRst_n                (iRst_n),
        .ienable               (ienable),
        .iPWRGD_PS_PWROK       (pwrok),
        .iFM_SLP3_N            (slp3),
        .iFM_SLP4_N            (slp4),
        .iFM_DIMM_12V_CPS_SX_N (cpsN),
        .oFM_AUX_SW_EN         (auxB),
        .oFM_S3_SW_P12V_STBY_EN(stbyB),
        .oFM_S3_SW_P12V_EN     (mainB),
        .oFault                (faultB),
        .oState                (stateB)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge iClk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp)
            nPass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Bounded wait for the MBB instance to reach a state, then compare.
    task automatic waitState(input logic [2:0] st, input int budget, input string tag);
        for (int i = 0; i < budget && stateA != st; i++)
            tick();
        check(tag, {29'd0, stateA}, {29'd0, st});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        iRst_n  = 1'b0;
        ienable = 1'b1;
        pwrok   = 1'b0;
        slp3    = 1'b0;
        slp4    = 1'b0;
        cpsN    = 2'b01;
        repeat (3) tick();

        // Reset state
        check("rst_state",  {29'd0, stateA}, 32'd0);
        check("rst_outsA",  {25'd0, auxA, stbyA, mainA, faultA}, 32'd0);
        check("rst_outsB",  {25'd0, auxB, stbyB, mainB, faultB}, 32'd0);

        // Test 1: leave reset into S45 with strap 01 -> STBY 10
        iRst_n = 1'b1;
        repeat (4) tick();
        check("s45_state", {29'd0, stateA}, {29'd0, c_S45});
        check("s45_outs",  {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_10_00});

        // Live strap change in S45, visible only after the synchroniser
        cpsN = 2'b10;
        repeat (2) tick();
        check("strap_delay", {30'd0, stbyA}, 32'b10);
        tick();
        check("strap_live",  {30'd0, stbyA}, 32'b01);

        // Test 2/3: power-up sequence
        slp4 = 1'b1;
        waitState(c_S3, 6, "to_s3");
        check("s3_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_00});
        cpsN = 2'b11;
        repeat (3) tick();
        check("strap_ignored_s3", {29'd0, stateA, 1'b0, stbyA}, {29'd0, c_S3, 3'b011});

        slp3 = 1'b1;
        waitState(c_S0WAIT, 6, "to_s0wait");
        check("s0wait_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_00});

        pwrok = 1'b1;
        waitState(c_S0HOLD, 10, "to_s0hold");
        n = 0;
        while (stateA == c_S0HOLD && n < 20) begin
            check("hold_mbb_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_11});
            check("hold_bbm_outs", {26'd0, auxB, stbyB, mainB}, 32'd0);
            tick();
            n++;
        end
        check("hold_len", n, 32'd8);
        check("s0on_state",  {29'd0, stateA, 1'b0, stateB}, {25'd0, c_S0ON, 1'b0, c_S0ON});
        check("s0on_outsA",  {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b11_00_11});
        check("s0on_outsB",  {26'd0, auxB, stbyB, mainB}, {26'd0, 6'b11_00_11});

        // Test 5: short glitch is filtered, longer drop is not
        pwrok = 1'b0;
        repeat (2) tick();
        pwrok = 1'b1;
        repeat (10) tick();
        check("glitch_filtered", {29'd0, stateA}, {29'd0, c_S0ON});

        pwrok = 1'b0;
        repeat (4) tick();
        pwrok = 1'b1;
        waitState(c_S0WAIT, 6, "drop_to_s0wait");
        check("drop_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_00});

        // Test 6: freeze inside the hold window at timer = 4
        waitState(c_S0HOLD, 8, "rehold");
        repeat (4) tick();
        ienable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("frozen_state", {29'd0, stateA}, {29'd0, c_S0HOLD});
        end
        check("frozen_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_11});
        ienable = 1'b1;
        repeat (3) tick();
        check("resume_still_hold", {29'd0, stateA}, {29'd0, c_S0HOLD});
        tick();
        check("resume_to_s0on", {29'd0, stateA}, {29'd0, c_S0ON});

        // Early S3 exit from the hold window
        pwrok = 1'b0;
        repeat (4) tick();
        pwrok = 1'b1;
        waitState(c_S0WAIT, 6, "early_s0wait");
        waitState(c_S0HOLD, 8, "early_s0hold");
        repeat (2) tick();
        slp3 = 1'b0;
        repeat (2) tick();
        check("early_sync_wait", {29'd0, stateA}, {29'd0, c_S0HOLD});
        tick();
        check("early_s3", {29'd0, stateA}, {29'd0, c_S3});
        check("early_s3_outs", {26'd0, auxA, stbyA, mainA}, {26'd0, 6'b00_11_00});
        // PWROK still good while SLP_S3# asserted -> back to INIT
        tick();
        check("s3_pwrok_init", {29'd0, stateA}, {29'd0, c_INIT});
        check("init_outs", {26'd0, auxA, stbyA, mainA}, 32'd0);

        // Test 4: PWROK timeout -> FAULT, cleared by SLP_S3#
        pwrok = 1'b0;
        slp4  = 1'b0;
        waitState(c_S45, 10, "t4_s45");
        slp4 = 1'b1;
        waitState(c_S3, 6, "t4_s3");
        slp3 = 1'b1;
        waitState(c_S0WAIT, 6, "t4_s0wait");
        n = 0;
        while (stateA == c_S0WAIT && n < 50) begin
            tick();
            n++;
        end
        check("timeout_len", n, 32'd32);
        check("fault_state", {29'd0, stateA}, {29'd0, c_FAULT});
        check("fault_flags", {30'd0, faultA, faultB}, 32'b11);
        check("fault_outs",  {26'd0, auxA, stbyA, mainA}, 32'd0);
        slp3 = 1'b0;
        repeat (2) tick();
        check("fault_sticky", {28'd0, stateA, faultA}, {28'd0, c_FAULT, 1'b1});
        tick();
        check("fault_exit", {28'd0, stateA, faultA}, {28'd0, c_INIT, 1'b0});

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psu_sw_seq.md
Name: psu_sw_seq

Overview:
- Multi-channel 12V source selector for DIMM/S3 VR rails, sitting between the PCH sleep signals and the per-channel rail switches.
- Tracks PCH S5/S4, S3 and S0 states and PSU power-good to choose between 12V_STBY and 12V main on each channel.
- Successor to the single-channel switch logic, adding:
  - per-channel CPS strap vector
  - selectable make-before-break or break-before-make hand-over
  - input synchronisation and power-good debounce
  - PWROK timeout fault state
  - early S3 exit from the hold window

Parameters:
NUM_CH, 2, number of switched rail channels (1..8)
HOLD_CYCLES, 50000, iClk cycles spent in S0HOLD before hand-over to main (1 ms at 50 MHz)
PWROK_TO_CYCLES, 5000000, max cycles in S0WAIT without debounced PWROK before FAULT (100 ms)
DEB_CYCLES, 500, consecutive stable cycles needed to change debounced PWROK (min 1)
MBB, 1, 1 = make-before-break (STBY and main both on in S0HOLD); 0 = break-before-make (both off in S0HOLD)

Ports:
iClk  in  1  system clock
iRst_n  in  1  reset, synchronous, active-low
ienable  in  1  master enable; 0 freezes FSM and timers (except in INIT)
iPWRGD_PS_PWROK  in  1  PSU power good, async
iFM_SLP3_N  in  1  PCH SLP_S3#, async
iFM_SLP4_N  in  1  PCH SLP_S4#, async
iFM_DIMM_12V_CPS_SX_N  in  NUM_CH  per-channel strap; 0 = keep STBY in S4/S5, async
oFM_AUX_SW_EN  out  NUM_CH  enable 12V main aux switch per channel
oFM_S3_SW_P12V_STBY_EN  out  NUM_CH  power channel VR from 12V_STBY
oFM_S3_SW_P12V_EN  out  NUM_CH  power channel VR from 12V main
oFault  out  1  PWROK timeout fault, sticky until exit condition
oState  out  3  current state code, for debug/BMC

Behaviour:
- Input path: all async inputs pass through a 2-flop synchroniser; FSM sees values 2 cycles late. Sync flops reset to 0.
- Debounce: pwrok_db takes the synchronised PWROK value only after that value has differed from pwrok_db for DEB_CYCLES consecutive cycles; any glitch restarts the count. pwrok_db resets to 0.
- State codes: INIT=0, S45=1, S3=2, S0WAIT=3, S0HOLD=4, S0ON=5, FAULT=6. Illegal code goes to INIT next cycle.
- Outputs are registered and decoded from next-state, so they change on the same edge the state changes.
- Reset values: every output vector is 0, oFault=0, oState=INIT, timers=0.
- Single shared timer, CNT_W = clog2(max(HOLD_CYCLES, PWROK_TO_CYCLES)+1). It clears on every state change, increments while in S0WAIT or S0HOLD, saturates at max, and holds while ienable=0.
- Priority per cycle: reset > ienable=0 freeze (not applied in INIT, which stays INIT) > transitions listed below, in the order given.
- Below, slp3 and slp4 are the synchronised active-low signals; slp3=0 means asserted (sleep).
- Transitions:
  - INIT -> S45 if ienable, slp3=0, slp4=0, pwrok_db=0; otherwise stay in INIT.
  - S45 -> S3 if slp3=0, slp4=1. Any of slp3=1 or pwrok_db=1 -> INIT. Otherwise stay in S45.
  - S3 -> S45 if slp4=0. -> S0WAIT if slp3=1, slp4=1, pwrok_db=0. pwrok_db=1 while slp3=0 -> INIT. Otherwise stay in S3.
  - S0WAIT -> S0HOLD if pwrok_db=1 and slp3=1. -> S3 if slp3=0, slp4=1. -> INIT if slp4=0. -> FAULT if timer = PWROK_TO_CYCLES-1.
  - S0HOLD -> S3 immediately if slp3=0, slp4=1. -> INIT if slp4=0. At timer = HOLD_CYCLES-1: -> S0ON if pwrok_db=1, else -> S0WAIT.
  - S0ON -> S3 if slp3=0, slp4=1. -> INIT if slp4=0. -> S0WAIT if pwrok_db=0. Otherwise stay in S0ON.
  - FAULT -> INIT when slp3=0. oFault=1 while in FAULT.
- Per-channel outputs (AUX, STBY, MAIN):
  - INIT and FAULT: 0, 0, 0.
  - S45: 0, ~CPS_N[ch], 0.
  - S3 and S0WAIT: 0, 1, 0.
  - S0HOLD with MBB=1: 0, 1, 1.
  - S0HOLD with MBB=0: 0, 0, 0.
  - S0ON: 1, 0, 1.
- AUX and STBY are never both 1 on any channel in any cycle.
- A strap change is honoured live in S45 (after the synchroniser delay) and ignored in all other states.
- Reset mid-sequence: the next edge forces INIT with all outputs 0, regardless of state.

Test Plan:
All tests use HOLD_CYCLES=8, PWROK_TO_CYCLES=32, DEB_CYCLES=3, NUM_CH=2.
1. Reset released with slp3=slp4=0, pwrok=0, CPS_N=2'b01, ienable=1 -> INIT then S45 within 3 cycles; STBY_EN=2'b10, MAIN=0, AUX=0.
2. Full power-up: slp4=1, then slp3=1, then pwrok=1 -> states S3, S0WAIT, S0HOLD. With MBB=1, STBY=MAIN=2'b11 for exactly 8 cycles; then S0ON with AUX=MAIN=2'b11, STBY=0.
3. Same as test 2 with MBB=0 -> all outputs 0 for the 8 S0HOLD cycles, then S0ON.
4. In S0WAIT, hold pwrok=0 for 32 cycles -> FAULT, oFault=1, outputs 0. Then drop slp3 -> INIT with oFault=0.
5. In S0ON, apply a 2-cycle pwrok glitch -> state stays S0ON. Apply a 4-cycle pwrok low -> S0WAIT with STBY=2'b11, AUX=0.
6. During S0HOLD at timer=4, deassert ienable for 10 cycles -> state and timer frozen. Re-enable -> S0ON after 4 more cycles. Separately, slp3=0 mid-hold -> S3 on the next post-sync edge.
